// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave front panel: keypad FSM encoding,
// keypad geometry and the default debounce interval.
package microwave_pkg;

  localparam int KEY_COUNT               = 10;
  localparam int KEY_CODE_W              = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 10000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } kp_state_t;

  function automatic logic [KEY_CODE_W-1:0] key_encode(input logic [KEY_COUNT-1:0] onehot);
    logic [KEY_CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (onehot[i]) code = KEY_CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce_if.sv
// Raw front-panel lines in, clean key pulses and button levels out.
interface keypad_debounce_if;
  import microwave_pkg::*;

  logic [KEY_COUNT-1:0]  keypad_raw;
  logic                  startn_raw;
  logic                  stopn_raw;
  logic                  clearn_raw;
  logic                  door_raw;
  logic [KEY_COUNT-1:0]  keypad;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  startn;
  logic                  stopn;
  logic                  clearn;
  logic                  door_closed;

  modport master (
    output keypad_raw, startn_raw, stopn_raw, clearn_raw, door_raw,
    input  keypad, key_code, key_valid, startn, stopn, clearn, door_closed
  );

  modport slave (
    input  keypad_raw, startn_raw, stopn_raw, clearn_raw, door_raw,
    output keypad, key_code, key_valid, startn, stopn, clearn, door_closed
  );

endinterface

// File: rtl/button_debounce.sv
// Single-line debouncer: two-flop synchronizer, stability counter and a
// level register that only follows the input after it has held steady.
module button_debounce
  import microwave_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] count;

  // Counter tops out at CNT_LAST and is cleared on flip or on any return to equality.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= RESET_VALUE;
      sync_q2 <= RESET_VALUE;
      count   <= '0;
      level   <= RESET_VALUE;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        level <= sync_q2;
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_debounce.sv
// Front-panel input conditioning: one-shot digit keypad plus four level
// debouncers for the start/stop/clear buttons and the door switch.
module keypad_debounce
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input logic              clk,
  input logic              rst,
  keypad_debounce_if.slave bus
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [KEY_COUNT-1:0] kp_q1;
  logic [KEY_COUNT-1:0] kp_q2;
  logic [KEY_COUNT-1:0] captured;
  logic [CNT_W-1:0]     count;
  kp_state_t            state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kp_q1 <= '0;
      kp_q2 <= '0;
    end else begin
      kp_q1 <= bus.keypad_raw;
      kp_q2 <= kp_q1;
    end
  end

  // The count that lands on CNT_HIT is the one that would reach DEBOUNCE_CYCLES-1,
  // so the pulse is registered on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      captured      <= '0;
      bus.keypad    <= '0;
      bus.key_code  <= '0;
      bus.key_valid <= 1'b0;
    end else begin
      bus.keypad    <= '0;
      bus.key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if ($onehot(kp_q2)) begin
            state    <= ARMING;
            captured <= kp_q2;
            count    <= '0;
          end else if (kp_q2 != '0) begin
            state <= PRESSED;
          end
        end
        ARMING: begin
          if (kp_q2 == '0) begin
            state <= IDLE;
          end else if (!$onehot(kp_q2)) begin
            state <= PRESSED;
          end else if (kp_q2 != captured) begin
            captured <= kp_q2;
            count    <= '0;
          end else if (count == CNT_HIT) begin
            state         <= PRESSED;
            bus.keypad    <= captured;
            bus.key_code  <= key_encode(captured);
            bus.key_valid <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (kp_q2 == '0) begin
            state <= RELEASING;
            count <= '0;
          end
        end
        RELEASING: begin
          if (kp_q2 != '0) begin
            state <= PRESSED;
          end else if (count == CNT_HIT) begin
            state <= IDLE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VALUE(1'b1)) u_start (
    .clk(clk), .rst(rst), .raw(bus.startn_raw), .level(bus.startn)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VALUE(1'b1)) u_stop (
    .clk(clk), .rst(rst), .raw(bus.stopn_raw), .level(bus.stopn)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VALUE(1'b1)) u_clear (
    .clk(clk), .rst(rst), .raw(bus.clearn_raw), .level(bus.clearn)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VALUE(1'b0)) u_door (
    .clk(clk), .rst(rst), .raw(bus.door_raw), .level(bus.door_closed)
  );

endmodule
